// File: rtl/cm_pkg.sv
// Shared types and helpers for the lib_cm arbitration blocks.
package cm_pkg;

  typedef enum logic [1:0] {ARB_MIN, ARB_MAX, ARB_RR} t_arb_algo;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_LOCK} t_arb_state;

  function automatic int sclog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width never collapses to zero, even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? sclog2(n) : 1;
  endfunction

endpackage

// File: rtl/cm_arb_pick.sv
// Combinational winner select: best weight over the mask, ties resolved from
// the rotating pointer (FAIR) or from index 0.
module cm_arb_pick
  import cm_pkg::*;
#(
  parameter int        DCNT      = 4,
  parameter int        DWIDTH    = 8,
  parameter t_arb_algo ALGO      = ARB_MIN,
  parameter bit        FAIR      = 1'b1,
  localparam int       IDX_WIDTH = idx_width(DCNT)
) (
  input  logic [DCNT-1:0]        mask,
  input  logic [DCNT*DWIDTH-1:0] weight,
  input  logic [IDX_WIDTH-1:0]   ptr,
  output logic                   found,
  output logic [IDX_WIDTH-1:0]   idx,
  output logic [DCNT-1:0]        onehot
);

  logic [DCNT-1:0][DWIDTH-1:0] w;
  logic [DWIDTH-1:0]           best;

  // Round-robin flattens every weight so the tie-break alone decides.
  for (genvar g = 0; g < DCNT; g++) begin : g_w
    assign w[g] = (ALGO == ARB_RR) ? '0 : weight[g*DWIDTH +: DWIDTH];
  end

  always_comb begin
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < DCNT; i++) begin
      if (mask[i]) begin
        if (!found ||
            ((ALGO == ARB_MAX) && (w[i] > best)) ||
            ((ALGO != ARB_MAX) && (w[i] < best)))
          best = w[i];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    int   j;
    logic hit;
    idx    = '0;
    onehot = '0;
    hit    = 1'b0;
    j      = 0;
    for (int k = 0; k < DCNT; k++) begin
      j = FAIR ? (k + int'(ptr)) : k;
      if (j >= DCNT) j = j - DCNT;
      if (!hit && mask[j] && (w[j] == best)) begin
        hit       = 1'b1;
        idx       = IDX_WIDTH'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cm_arbiter_fair.sv
// Weighted arbiter with valid/ready grant handshake, rotating tie-break and
// optional grant lock across multi-beat transfers.
module cm_arbiter_fair
  import cm_pkg::*;
#(
  parameter int        DCNT      = 4,
  parameter int        DWIDTH    = 8,
  parameter t_arb_algo ALGO      = ARB_MIN,
  parameter bit        FAIR      = 1'b1,
  localparam int       IDX_WIDTH = idx_width(DCNT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DCNT-1:0]        i_req,
  input  logic [DCNT*DWIDTH-1:0] i_weight,
  input  logic                   i_rdy,
  input  logic                   i_lock,
  output logic                   o_vld,
  output logic [IDX_WIDTH-1:0]   o_gnt,
  output logic [DCNT-1:0]        o_gnt_oh,
  output logic                   o_lck
);

  t_arb_state           state, state_n;
  logic [IDX_WIDTH-1:0] ptr, ptr_n, ptr_inc, gnt_n;
  logic [DCNT-1:0]      oh_n;
  logic                 cur_req;

  logic                 pr_found, po_found;
  logic [IDX_WIDTH-1:0] pr_idx, po_idx;
  logic [DCNT-1:0]      pr_oh, po_oh;

  assign ptr_inc = (o_gnt == IDX_WIDTH'(DCNT-1)) ? '0 : o_gnt + 1'b1;
  assign cur_req = |(i_req & o_gnt_oh);

  // Fresh pick: idle arbitration and re-pick after a withdrawn grant.
  cm_arb_pick #(.DCNT(DCNT), .DWIDTH(DWIDTH), .ALGO(ALGO), .FAIR(FAIR)) u_pick_req (
    .mask   (i_req),
    .weight (i_weight),
    .ptr    (ptr),
    .found  (pr_found),
    .idx    (pr_idx),
    .onehot (pr_oh)
  );

  // Follow-on pick after a handshake or lock release: current owner excluded,
  // tie-break already advanced past it.
  cm_arb_pick #(.DCNT(DCNT), .DWIDTH(DWIDTH), .ALGO(ALGO), .FAIR(FAIR)) u_pick_nxt (
    .mask   (i_req & ~o_gnt_oh),
    .weight (i_weight),
    .ptr    (ptr_inc),
    .found  (po_found),
    .idx    (po_idx),
    .onehot (po_oh)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = o_gnt;
    oh_n    = o_gnt_oh;
    case (state)
      ARB_IDLE: begin
        if (pr_found) begin
          state_n = ARB_GRANT;
          gnt_n   = pr_idx;
          oh_n    = pr_oh;
        end
      end
      ARB_GRANT: begin
        if (i_rdy) begin
          ptr_n = ptr_inc;
          if (i_lock) begin
            state_n = ARB_LOCK;
          end else if (po_found) begin
            gnt_n = po_idx;
            oh_n  = po_oh;
          end else begin
            state_n = ARB_IDLE;
            oh_n    = '0;
          end
        end else if (!cur_req) begin
          if (pr_found) begin
            gnt_n = pr_idx;
            oh_n  = pr_oh;
          end else begin
            state_n = ARB_IDLE;
            oh_n    = '0;
          end
        end
      end
      ARB_LOCK: begin
        if (!i_lock) begin
          if (po_found) begin
            state_n = ARB_GRANT;
            gnt_n   = po_idx;
            oh_n    = po_oh;
          end else begin
            state_n = ARB_IDLE;
            oh_n    = '0;
          end
        end
      end
      default: begin
        state_n = ARB_IDLE;
        oh_n    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      o_gnt    <= '0;
      o_gnt_oh <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      o_gnt    <= gnt_n;
      o_gnt_oh <= oh_n;
    end
  end

  assign o_vld = (state == ARB_GRANT);
  assign o_lck = (state == ARB_LOCK);

endmodule
